afe_spi_arbiter: RTL
====================

Name: afe_spi_arbiter

Overview:
Shares one AFE SPI engine between NREQ independent requesters, for example the init sequencer, the CSR/software path and the attenuator calibration loop.
- Accepts 32-bit SPI command words from each requester; command word format is identical to the engine's gpioOut.
- Picks one requester round-robin, strobes the engine and tracks its busy bit.
- Returns the 24-bit shift-register readback to the granted requester.
- A watchdog recovers from an engine that never starts or never finishes.

Parameters:
NREQ, 3, number of requesters (2..8).
START_TIMEOUT, 8, max cycles from strobe to engine busy=1 before declaring an error.
DONE_TIMEOUT, 4096, max cycles engine busy may stay high before declaring an error.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
reqValid  input  NREQ  per-requester command valid; held until reqReady.
reqCommand  input  32*NREQ  per-requester command word; requester i occupies bits [32*i+:32].
reqReady  output  NREQ  one-hot, one-cycle accept pulse.
respValid  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
respData  output  24  readback data; valid with respValid.
respError  output  1  timeout flag; valid with respValid.
spiStrobe  output  1  csrStrobe to the engine.
spiCommand  output  32  gpioOut to the engine.
spiStatus  input  32  engine status; bit 31 = busy, bits [23:0] = shiftReg.
grantIndex  output  $clog2(NREQ) (min 1)  index of the current or last granted requester.
errorCount  output  16  saturating count of timeouts.

Behaviour:
Reset values:
- reqReady = 0, respValid = 0, spiStrobe = 0.
- spiCommand = 0, respData = 0, respError = 0.
- grantIndex = 0, errorCount = 0.
- Round-robin pointer = 0; state = S_IDLE.
- Reset mid-transfer drops the transaction silently: no respValid. The engine completes on its own, and the arbiter waits in S_IDLE until spiStatus[31] = 0 before issuing again.

States:
- S_IDLE
  - Issues only if any reqValid is set and spiStatus[31] = 0.
  - Winner = first set bit searching from pointer upward, with wrap.
  - In that cycle: register spiCommand = the winner's reqCommand, pulse reqReady[winner], set grantIndex, pointer <= winner+1 (mod NREQ).
  - Then go to S_STROBE.
- S_STROBE
  - spiStrobe = 1 for exactly one cycle; spiCommand is stable from S_IDLE onward.
  - Start counter cleared; go to S_WAIT_START.
- S_WAIT_START
  - spiStatus[31] = 1 -> S_WAIT_DONE, clear counter.
  - Counter reaches START_TIMEOUT -> S_RESPOND with error.
  - Note: the engine raises busy one cycle after the strobe.
- S_WAIT_DONE
  - spiStatus[31] = 0 -> capture spiStatus[23:0] into respData, error = 0, go to S_RESPOND.
  - Counter reaches DONE_TIMEOUT -> S_RESPOND with error = 1, respData = spiStatus[23:0].
- S_RESPOND
  - respValid[grantIndex] = 1 for one cycle and respError set.
  - On error, errorCount increments, saturating at 0xFFFF.
  - Go to S_IDLE.

Handshake and timing rules:
- spiCommand holds its last value between transactions; it is never changed while the engine is busy.
- Minimum issue-to-issue spacing is bounded by the engine; the arbiter adds 3 cycles of overhead.
- Simultaneous requests are served strictly round-robin. A requester re-asserting immediately after its response waits behind the other pending requesters.
- A reqValid deasserted before reqReady is treated as withdrawn; this is legal.
- Single requester: it is granted back to back.
- Data alignment is the engine's responsibility:
  - 16-bit MSB-first readback appears in respData[15:0].
  - 16-bit LSB-first readback appears in respData[23:8].
  - The arbiter does not realign.

Decomposition:
Shared package afe_spi_pkg holds:
- command field constants: CMD_LARGE_BIT = 31, CMD_LSB_FIRST_BIT = 30, CMD_DEVSEL_LSB = 24, CMD_DATA_WIDTH = 24;
- STATUS_BUSY_BIT = 31;
- state encoding.

One natural sub-module: rr_priority_select (NREQ request vector + pointer -> one-hot grant + index; combinational). The watchdog counter stays inline.

Test Plan:
1. Single request. Requester 0 sends 0x8012_3456; an engine model runs 40 busy cycles, then returns 0xABCDEF.
   -> reqReady[0] asserts once; spiStrobe pulses once with spiCommand = 0x8012_3456; respValid[0] pulses with respData = 0xABCDEF and respError = 0.
2. All three requesters assert in the same cycle with commands 0x1, 0x2, 0x3.
   -> Grant order is 0, 1, 2; exactly three strobes occur, each issued only after busy falls; each respValid goes to the correct index.
3. Fairness. Requester 0 re-requests continuously while requester 2 is pending.
   -> Grants alternate 0, 2, 0, 2; requester 1 is never granted.
4. Engine never raises busy.
   -> After 8 cycles in S_WAIT_START, respValid pulses with respError = 1 and errorCount = 1; the next request is served normally.
5. Busy stuck high.
   -> Timeout fires at 4096 cycles with respError = 1. Once busy releases, the pending request is issued only after spiStatus[31] = 0.
6. Reset asserted during S_WAIT_DONE.
   -> No respValid; all outputs return to reset values; a new request is not strobed until engine busy = 0.

Source files
------------

// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared command/status field constants and arbiter state encoding
package afe_spi_pkg;
  localparam int CMD_LARGE_BIT = 31;
  localparam int CMD_LSB_FIRST_BIT = 30;
  localparam int CMD_DEVSEL_LSB = 24;
  localparam int CMD_DATA_WIDTH = 24;
  localparam int STATUS_BUSY_BIT = 31;
  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: req vector + rotating pointer -> one-hot grant, grant index and any-request flag
module rr_priority_select
  import afe_spi_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    any = |req;
  end
endmodule

// File: rtl/afe_spi_arbiter.sv
// afe_spi_arbiter: round-robin sharing of one AFE SPI engine among NREQ requesters (req*/resp* per requester, spi* to engine, watchdog errorCount)
module afe_spi_arbiter
  import afe_spi_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int START_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 4096,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      reqValid,
  input  logic [32*NREQ-1:0]   reqCommand,
  output logic [NREQ-1:0]      reqReady,
  output logic [NREQ-1:0]      respValid,
  output logic [23:0]          respData,
  output logic                 respError,
  output logic                 spiStrobe,
  output logic [31:0]          spiCommand,
  input  logic [31:0]          spiStatus,
  output logic [IW-1:0]        grantIndex,
  output logic [15:0]          errorCount
);
  localparam int CW = $clog2((START_TIMEOUT > DONE_TIMEOUT ? START_TIMEOUT : DONE_TIMEOUT) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ptr, win_idx;
  logic [NREQ-1:0] win;
  logic any, busy, issue, done, err_n;
  logic unused_status;
  assign busy = spiStatus[STATUS_BUSY_BIT];
  assign unused_status = ^spiStatus[STATUS_BUSY_BIT-1:CMD_DATA_WIDTH];
  rr_priority_select #(.N(NREQ), .IW(IW)) u_sel (
    .req(reqValid),
    .ptr(ptr),
    .grant(win),
    .idx(win_idx),
    .any(any)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    issue = 1'b0;
    done = 1'b0;
    err_n = 1'b0;
    case (state)
      S_IDLE: begin
        issue = any && !busy;
        state_n = issue ? S_STROBE : S_IDLE;
      end
      S_STROBE: begin
        cnt_n = '0;
        state_n = S_WAIT_START;
      end
      S_WAIT_START:
        if (busy) begin
          state_n = S_WAIT_DONE;
          cnt_n = '0;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          state_n = S_RESPOND;
          done = 1'b1;
          err_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      S_WAIT_DONE:
        if (!busy) begin
          state_n = S_RESPOND;
          done = 1'b1;
        end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
          state_n = S_RESPOND;
          done = 1'b1;
          err_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      S_RESPOND: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      grantIndex <= '0;
      spiCommand <= '0;
      respData <= '0;
      respError <= 1'b0;
      errorCount <= '0;
    end else begin
      if (issue) begin
        spiCommand <= reqCommand[32*win_idx +: 32];
        grantIndex <= win_idx;
        ptr <= win_idx == IW'(NREQ - 1) ? '0 : win_idx + 1'b1;
      end
      if (done) begin
        respData <= spiStatus[CMD_DATA_WIDTH-1:0];
        respError <= err_n;
      end
      if (state == S_RESPOND && respError && errorCount != 16'hFFFF) errorCount <= errorCount + 1'b1;
    end
  // reqReady is gated by reset so a held reqValid is never accepted while the block is in reset
  assign reqReady = (issue && !reset) ? win : '0;
  assign spiStrobe = state == S_STROBE;
  assign respValid = state == S_RESPOND ? NREQ'(1) << grantIndex : '0;
endmodule
